// File: rtl/computer_pkg.sv
// Shared opcode, ALU and bus-select constants plus control FSM state encoding.
// S_ADDB exists only when ADDAB_LDB_EN is defined.
package computer_pkg;

    localparam logic [7:0] OP_LDA_IMM  = 8'h86;
    localparam logic [7:0] OP_LDA_DIR  = 8'h87;
    localparam logic [7:0] OP_LDB_IMM  = 8'h88;
    localparam logic [7:0] OP_LDB_DIR  = 8'h89;
    localparam logic [7:0] OP_STA_DIR  = 8'h96;
    localparam logic [7:0] OP_STB_DIR  = 8'h97;
    localparam logic [7:0] OP_ADD_AB   = 8'h42;
    localparam logic [7:0] OP_SUB_AB   = 8'h43;
    localparam logic [7:0] OP_AND_AB   = 8'h44;
    localparam logic [7:0] OP_OR_AB    = 8'h45;
    localparam logic [7:0] OP_INCA     = 8'h46;
    localparam logic [7:0] OP_INCB     = 8'h47;
    localparam logic [7:0] OP_DECA     = 8'h48;
    localparam logic [7:0] OP_DECB     = 8'h49;
    localparam logic [7:0] OP_XOR_AB   = 8'h4A;
    localparam logic [7:0] OP_NOTA     = 8'h4B;
    localparam logic [7:0] OP_NOTB     = 8'h4C;
    localparam logic [7:0] OP_ADD_AB_B = 8'h4D;
    localparam logic [7:0] OP_BRA      = 8'h20;
    localparam logic [7:0] OP_BMI      = 8'h21;
    localparam logic [7:0] OP_BPL      = 8'h22;
    localparam logic [7:0] OP_BEQ      = 8'h23;
    localparam logic [7:0] OP_BNE      = 8'h24;
    localparam logic [7:0] OP_BVS      = 8'h25;
    localparam logic [7:0] OP_BVC      = 8'h26;
    localparam logic [7:0] OP_BCS      = 8'h27;
    localparam logic [7:0] OP_BCC      = 8'h28;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_INC, ALU_DEC, ALU_XOR, ALU_NOT
    } alu_sel_t;

    localparam logic [1:0] B1_PC = 2'd0, B1_A = 2'd1, B1_B = 2'd2;
    localparam logic [1:0] B2_ALU = 2'd0, B2_BUS1 = 2'd1, B2_MEM = 2'd2;

    typedef enum logic [4:0] {
        S_F0, S_FW1, S_FWN, S_F2, S_DEC,
        S_OP0, S_OPW1, S_OPWN, S_LDIA, S_LDIB,
        S_DMAR, S_DW, S_LDDA, S_LDDB, S_STA, S_STB,
        S_ALUA, S_ALUB, S_BR0, S_BW, S_BLD, S_BSKIP
`ifdef ADDAB_LDB_EN
        , S_ADDB
`endif
    } state_t;

    function automatic alu_sel_t alu_code(input logic [7:0] op);
        case (op)
            OP_ADD_AB, OP_ADD_AB_B: alu_code = ALU_ADD;
            OP_SUB_AB:              alu_code = ALU_SUB;
            OP_AND_AB:              alu_code = ALU_AND;
            OP_OR_AB:               alu_code = ALU_OR;
            OP_INCA, OP_INCB:       alu_code = ALU_INC;
            OP_DECA, OP_DECB:       alu_code = ALU_DEC;
            OP_XOR_AB:              alu_code = ALU_XOR;
            OP_NOTA, OP_NOTB:       alu_code = ALU_NOT;
            default:                alu_code = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition: opcodes 21..28 pair up as (flag set, flag clear) over N,Z,V,C.
import computer_pkg::*;

module branch_eval (
    input  logic [7:0] op,
    input  logic [3:0] ccr,
    output logic       taken
);
    logic [2:0] k;
    logic [1:0] idx;

    always_comb begin
        k     = op[2:0] - 3'd1;
        idx   = 2'd3 - k[2:1];
        taken = (op == OP_BRA) | (ccr[idx] ^ k[0]);
    end
endmodule

// File: rtl/control_unit.sv
// Moore control FSM with registered strobes for the 8-bit accumulator computer.
// Define ADDAB_LDB_EN to enable opcode 4D (A+B into B).
import computer_pkg::*;

module control_unit #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       CCR_Load,
    output logic       write,
    output logic [2:0] ALU_Sel,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel
);
    localparam logic [1:0] WAIT_INIT = 2'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);
    // With no wait cycles, the PC increment moves to the cycle that consumes memory data.
    localparam logic       INC_LATE  = (MEM_WAIT == 0);

    state_t     state, nxt, after_op, after_dw;
    logic       run, taken, wdone, in_wait;
    logic [1:0] wcnt;

    branch_eval u_branch (.op(IR), .ccr(CCR_Result), .taken(taken));

    always_comb begin
        wdone    = (wcnt == 2'd0);
        in_wait  = state inside {S_FW1, S_FWN, S_OPW1, S_OPWN, S_DW, S_BW};
        after_op = (IR == OP_LDA_IMM) ? S_LDIA : (IR == OP_LDB_IMM) ? S_LDIB : S_DMAR;
        after_dw = (IR == OP_LDB_DIR) ? S_LDDB : S_LDDA;
        nxt      = S_F0;
        // The first edge after reset only arms the machine so F0 strobes appear on it.
        if (run) begin
            case (state)
                S_F0:          nxt = (MEM_WAIT == 0) ? S_F2 : S_FW1;
                S_FW1, S_FWN:  nxt = wdone ? S_F2 : S_FWN;
                S_F2:          nxt = S_DEC;
                S_DEC: begin
                    case (IR)
                        OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR,
                        OP_STA_DIR, OP_STB_DIR:                     nxt = S_OP0;
                        OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB,
                        OP_INCA, OP_DECA, OP_XOR_AB, OP_NOTA:       nxt = S_ALUA;
                        OP_INCB, OP_DECB, OP_NOTB:                  nxt = S_ALUB;
`ifdef ADDAB_LDB_EN
                        OP_ADD_AB_B:                                nxt = S_ADDB;
`endif
                        OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
                        OP_BVS, OP_BVC, OP_BCS, OP_BCC:             nxt = taken ? S_BR0 : S_BSKIP;
                        default:                                    nxt = S_F0;
                    endcase
                end
                S_OP0:          nxt = (MEM_WAIT == 0) ? after_op : S_OPW1;
                S_OPW1, S_OPWN: nxt = wdone ? after_op : S_OPWN;
                S_DMAR: begin
                    if (IR == OP_STA_DIR)      nxt = S_STA;
                    else if (IR == OP_STB_DIR) nxt = S_STB;
                    else                       nxt = (MEM_WAIT == 0) ? after_dw : S_DW;
                end
                S_DW:    nxt = wdone ? after_dw : S_DW;
                S_BR0:   nxt = (MEM_WAIT == 0) ? S_BLD : S_BW;
                S_BW:    nxt = wdone ? S_BLD : S_BW;
                default: nxt = S_F0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_F0;
            run      <= 1'b0;
            wcnt     <= 2'd0;
            IR_Load  <= 1'b0;
            MAR_Load <= 1'b0;
            PC_Load  <= 1'b0;
            PC_Inc   <= 1'b0;
            A_Load   <= 1'b0;
            B_Load   <= 1'b0;
            CCR_Load <= 1'b0;
            write    <= 1'b0;
            ALU_Sel  <= 3'd0;
            Bus1_Sel <= B1_PC;
            Bus2_Sel <= B2_ALU;
        end else begin
            run      <= 1'b1;
            state    <= nxt;
            wcnt     <= in_wait ? (wdone ? 2'd0 : wcnt - 2'd1) : WAIT_INIT;
            IR_Load  <= 1'b0;
            MAR_Load <= 1'b0;
            PC_Load  <= 1'b0;
            PC_Inc   <= 1'b0;
            A_Load   <= 1'b0;
            B_Load   <= 1'b0;
            CCR_Load <= 1'b0;
            write    <= 1'b0;
            ALU_Sel  <= 3'd0;
            Bus1_Sel <= B1_PC;
            Bus2_Sel <= B2_ALU;
            case (nxt)
                S_F0, S_OP0, S_BR0: begin
                    MAR_Load <= 1'b1;
                    Bus1_Sel <= B1_PC;
                    Bus2_Sel <= B2_BUS1;
                end
                S_FW1, S_OPW1, S_BSKIP: PC_Inc <= 1'b1;
                S_F2: begin
                    IR_Load  <= 1'b1;
                    Bus2_Sel <= B2_MEM;
                    PC_Inc   <= INC_LATE;
                end
                S_LDIA, S_LDIB: begin
                    A_Load   <= (nxt == S_LDIA);
                    B_Load   <= (nxt == S_LDIB);
                    Bus2_Sel <= B2_MEM;
                    PC_Inc   <= INC_LATE;
                end
                S_DMAR: begin
                    MAR_Load <= 1'b1;
                    Bus2_Sel <= B2_MEM;
                    PC_Inc   <= INC_LATE;
                end
                S_LDDA, S_LDDB: begin
                    A_Load   <= (nxt == S_LDDA);
                    B_Load   <= (nxt == S_LDDB);
                    Bus2_Sel <= B2_MEM;
                end
                S_STA, S_STB: begin
                    write    <= 1'b1;
                    Bus1_Sel <= (nxt == S_STA) ? B1_A : B1_B;
                    Bus2_Sel <= B2_BUS1;
                end
                S_ALUA, S_ALUB: begin
                    A_Load   <= (nxt == S_ALUA);
                    B_Load   <= (nxt == S_ALUB);
                    CCR_Load <= 1'b1;
                    ALU_Sel  <= alu_code(IR);
                    Bus1_Sel <= (nxt == S_ALUA) ? B1_A : B1_B;
                    Bus2_Sel <= B2_ALU;
                end
`ifdef ADDAB_LDB_EN
                S_ADDB: begin
                    B_Load   <= 1'b1;
                    CCR_Load <= 1'b1;
                    ALU_Sel  <= ALU_ADD;
                    Bus1_Sel <= B1_A;
                    Bus2_Sel <= B2_ALU;
                end
`endif
                S_BLD: begin
                    PC_Load  <= 1'b1;
                    Bus2_Sel <= B2_MEM;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Random-instruction bench: compares every cycle's strobe word to a per-instruction cycle list.
module tb_control_unit;
    localparam int MW = 1;

    localparam logic [14:0] IRL  = 15'h4000, MARL = 15'h2000, PCL  = 15'h1000, PCI = 15'h0800;
    localparam logic [14:0] AL   = 15'h0400, BL   = 15'h0200, CCRL = 15'h0100, WR  = 15'h0080;
    localparam logic [14:0] S1_A = 15'h0004, S1_B = 15'h0008, S2_B1 = 15'h0001, S2_MEM = 15'h0002;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic [14:0] obs;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];
    logic [7:0]  ops[$] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                            8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
                            8'h4A, 8'h4B, 8'h4C, 8'h4D,
                            8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};

    control_unit #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .write(write),
        .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel)
    );

    always #5 clk = ~clk;

    assign obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write,
                  ALU_Sel, Bus1_Sel, Bus2_Sel};

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] alu(input int sel);
        return 15'(sel) << 4;
    endfunction

    task automatic waits(input bit first_inc);
        for (int i = 0; i < MW; i++) exp_q.push_back((first_inc && i == 0) ? PCI : 15'h0);
    endtask

    // Expected strobe words, one per clock, for a whole instruction starting at F0.
    task automatic build(input logic [7:0] ir, input logic [3:0] ccr);
        logic [14:0] late;
        logic        tk;
        late = (MW == 0) ? PCI : 15'h0;
        exp_q.delete();
        exp_q.push_back(MARL | S2_B1);
        waits(1'b1);
        exp_q.push_back(IRL | S2_MEM | late);
        exp_q.push_back(15'h0);
        case (ir)
            8'h86, 8'h88: begin
                exp_q.push_back(MARL | S2_B1);
                waits(1'b1);
                exp_q.push_back(((ir == 8'h86) ? AL : BL) | S2_MEM | late);
            end
            8'h87, 8'h89: begin
                exp_q.push_back(MARL | S2_B1);
                waits(1'b1);
                exp_q.push_back(MARL | S2_MEM | late);
                waits(1'b0);
                exp_q.push_back(((ir == 8'h87) ? AL : BL) | S2_MEM);
            end
            8'h96, 8'h97: begin
                exp_q.push_back(MARL | S2_B1);
                waits(1'b1);
                exp_q.push_back(MARL | S2_MEM | late);
                exp_q.push_back(WR | S2_B1 | ((ir == 8'h96) ? S1_A : S1_B));
            end
            8'h42: exp_q.push_back(AL | CCRL | S1_A | alu(0));
            8'h43: exp_q.push_back(AL | CCRL | S1_A | alu(1));
            8'h44: exp_q.push_back(AL | CCRL | S1_A | alu(2));
            8'h45: exp_q.push_back(AL | CCRL | S1_A | alu(3));
            8'h46: exp_q.push_back(AL | CCRL | S1_A | alu(4));
            8'h47: exp_q.push_back(BL | CCRL | S1_B | alu(4));
            8'h48: exp_q.push_back(AL | CCRL | S1_A | alu(5));
            8'h49: exp_q.push_back(BL | CCRL | S1_B | alu(5));
            8'h4A: exp_q.push_back(AL | CCRL | S1_A | alu(6));
            8'h4B: exp_q.push_back(AL | CCRL | S1_A | alu(7));
            8'h4C: exp_q.push_back(BL | CCRL | S1_B | alu(7));
`ifdef ADDAB_LDB_EN
            8'h4D: exp_q.push_back(BL | CCRL | S1_A | alu(0));
`endif
            8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28: begin
                case (ir)
                    8'h21:   tk = ccr[3] == 1'b1;
                    8'h22:   tk = ccr[3] == 1'b0;
                    8'h23:   tk = ccr[2] == 1'b1;
                    8'h24:   tk = ccr[2] == 1'b0;
                    8'h25:   tk = ccr[1] == 1'b1;
                    8'h26:   tk = ccr[1] == 1'b0;
                    8'h27:   tk = ccr[0] == 1'b1;
                    8'h28:   tk = ccr[0] == 1'b0;
                    default: tk = 1'b1;
                endcase
                if (tk) begin
                    exp_q.push_back(MARL | S2_B1);
                    waits(1'b0);
                    exp_q.push_back(PCL | S2_MEM);
                end else begin
                    exp_q.push_back(PCI);
                end
            end
            default: ;
        endcase
    endtask

    // IR/CCR are presented during F0; CCR is scrambled once DECODE has been consumed.
    task automatic run(input logic [7:0] ir, input logic [3:0] ccr, input bit abort);
        build(ir, ccr);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("op%02h_c%0d_ccr%h", ir, i, ccr), obs, exp_q[i]);
            if (i == 0) begin
                IR = ir;
                CCR_Result = ccr;
            end
            if (i == MW + 3) CCR_Result = 4'($urandom);
            if (abort && i == exp_q.size() - 2) break;
        end
    endtask

    initial begin
        reset = 1'b0;
        IR = 8'h00;
        CCR_Result = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", obs, 15'h0);
        @(negedge clk);
        reset = 1'b1;

        run(8'h86, 4'h0, 1'b0);
        run(8'h42, 4'($urandom), 1'b0);
        run(8'h26, 4'b0000, 1'b0);
        run(8'h26, 4'b0010, 1'b0);
        run(8'h96, 4'($urandom), 1'b0);
        run(8'h97, 4'($urandom), 1'b0);
        run(8'h4D, 4'($urandom), 1'b0);
        run(8'h20, 4'($urandom), 1'b0);
        run(8'hFF, 4'($urandom), 1'b0);

        // Abort LDA_DIR in its data wait cycle.
        run(8'h87, 4'h0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_async", obs, 15'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold", obs, 15'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        run(8'h87, 4'($urandom), 1'b0);

        repeat (80) begin
            logic [7:0] op;
            if ($urandom_range(0, 3) == 0) op = 8'($urandom);
            else op = ops[$urandom_range(0, ops.size() - 1)];
            run(op, 4'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1: memory read wait cycles between MAR load and data use, legal 0..3.
REQ-002 SHALL have port clk, input, 1, system clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port IR, input, 8, current instruction register contents.
REQ-005 SHALL have port CCR_Result, input, 4, flags {N,Z,V,C} in bits [3:0].
REQ-006 SHALL have outputs IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write, each 1 bit: datapath strobes.
REQ-007 SHALL have output ALU_Sel, 3 bits, with codes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 INC, 5 DEC, 6 XOR, 7 NOT.
REQ-008 SHALL have outputs Bus1_Sel, 2 bits (0 PC, 1 A, 2 B) and Bus2_Sel, 2 bits (0 ALU, 1 Bus1, 2 from_memory).

Function
REQ-009 SHALL be a Moore FSM; all outputs decode from the state register only, with every output defaulting to 0 in each state.
REQ-010 Fetch SHALL run F0 (Bus1=PC, Bus2=Bus1, MAR_Load), then MEM_WAIT cycles with PC_Inc asserted in the first one, then F2 (Bus2=mem, IR_Load), then DECODE.
REQ-011 When MEM_WAIT=0, PC_Inc SHALL be asserted in F2 instead.
REQ-012 DECODE SHALL last one cycle and select the instruction path from IR.
REQ-013 Opcodes LDA_IMM 86, LDB_IMM 88 SHALL perform operand fetch (MAR<=PC, PC_Inc, wait) and then load the register from mem: 2+MEM_WAIT cycles.
REQ-014 Opcodes LDA_DIR 87, LDB_DIR 89 SHALL perform operand fetch, then MAR_Load from mem, then MEM_WAIT waits, then load the register from mem.
REQ-015 Opcodes STA_DIR 96, STB_DIR 97 SHALL perform operand fetch and MAR_Load from mem, then one cycle driving Bus1 with the register, Bus2=Bus1 and write=1.
REQ-016 ALU opcodes 42-4B SHALL take one execute cycle: Bus1=A, Bus2=ALU, the matching ALU_Sel, A_Load and CCR_Load.
REQ-017 Opcodes 4C NOTB, 47 INCB and 49 DECB SHALL use Bus1=B and B_Load instead.
REQ-018 Branches 20-28 SHALL test the flag given by the opcode.
REQ-019 A taken branch SHALL run MAR<=PC, then wait, then Bus2=mem with PC_Load.
REQ-020 A not-taken branch SHALL take one cycle with PC_Inc to skip the operand.
REQ-021 BRA SHALL always be taken.
REQ-022 Flags SHALL be sampled in the DECODE cycle.
REQ-023 Any undefined opcode SHALL execute as a NOP and return to F0 after DECODE.
REQ-024 Every instruction path SHALL end by returning to F0; no state SHALL be unreachable or a dead end, and illegal state encodings SHALL go to F0.

Reset
REQ-025 reset low SHALL immediately force state F0 and all outputs to 0, independent of clk.
REQ-026 Reset mid-instruction SHALL abort it with no further strobes.
REQ-027 On the first rising edge after reset deasserts, the F0 strobes SHALL be in effect.

Configuration
REQ-028 With ADDAB_LDB_EN defined, opcode 4D SHALL execute Bus1=A, Bus2=ALU, ALU_Sel=ADD, B_Load and CCR_Load in one cycle.
REQ-029 With ADDAB_LDB_EN undefined, opcode 4D SHALL be treated as an undefined opcode (NOP).

Structure
REQ-030 Opcode constants, ALU_Sel codes and Bus1/Bus2 select codes SHALL live in shared package computer_pkg, which the ROM image also uses.
REQ-031 The state encoding SHALL be a typedef in computer_pkg.
REQ-032 One sub-module, branch_eval (opcode + CCR -> taken), is natural and SHALL be used.

Verification
REQ-033 With MEM_WAIT=1 and IR=86 (LDA_IMM), the bench SHALL see F0 MAR_Load, PC_Inc, IR_Load, decode, MAR_Load, PC_Inc, then A_Load with Bus2=2, and F0 at cycle 8.
REQ-034 With IR=42 (ADD_AB), the bench SHALL see exactly one cycle with A_Load=1, CCR_Load=1 and ALU_Sel=0 after DECODE.
REQ-035 With IR=26 (BVC), the bench SHALL see: for CCR=0000, PC_Load asserted once; for CCR=0010, a single PC_Inc and no PC_Load.
REQ-036 With IR=96 (STA_DIR), the bench SHALL see write=1 for exactly one cycle with Bus1_Sel=1, and write=0 elsewhere.
REQ-037 Driving reset low during a LDA_DIR wait state SHALL drop all outputs to 0 the same cycle, and after release the bench SHALL see F0 behaviour.
REQ-038 With IR=4D, the bench SHALL see B_Load once when ADDAB_LDB_EN is defined, and no load strobes when it is undefined.
